// File: rtl/leb128_reader.sv
// LEB128 fetch/decode front end: walks ROM bytes from start_addr and returns one u32 (s32 with LEB128_SIGNED_EN).
// Optional feature macro: LEB128_SIGNED_EN adds the is_signed input and sign-extension/5th-byte sign checks.
module leb128_reader #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] start_addr,
`ifdef LEB128_SIGNED_EN
  input  logic        is_signed,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] value,
  output logic [2:0]  nbytes,
  output logic [31:0] next_addr,
  output logic [1:0]  err_code,
  output logic [31:0] rom_addr,
  output logic        rom_read_en,
  input  logic [7:0]  rom_data,
  input  logic        rom_ready
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, FINISH} state_t;

  state_t        r_state;
  logic [31:0]   r_cur;
  logic [31:0]   r_base;
  logic [31:0]   r_acc;
  logic [4:0]    r_shift;
  logic [2:0]    r_cnt;
  logic [TW-1:0] r_tmo;
  logic          r_signed;

  logic          w_last;
  logic          w_term;
  logic          w_hi_bad;
  logic [31:0]   w_acc;
  logic [31:0]   w_val;
  logic [2:0]    w_cnt;
  logic [1:0]    w_err;
  logic [5:0]    w_ext_sh;

  always_comb begin
    w_last   = (r_cnt == 3'd4);
    w_acc    = r_acc | ({25'd0, rom_data[6:0]} << r_shift);
    w_cnt    = r_cnt + 3'd1;
    w_term   = ~rom_data[7] | w_last;
    w_ext_sh = {1'b0, r_shift} + 6'd7;
    w_val    = w_acc;
`ifdef LEB128_SIGNED_EN
    // 5th byte carries bit 31 in [3]; everything above must replicate it
    w_hi_bad = r_signed ? !((rom_data[6:3] == 4'h0) || (rom_data[6:3] == 4'hF))
                        : (rom_data[6:4] != 3'd0);
    if (r_signed && !w_last && rom_data[6])
      w_val = w_acc | (32'hFFFF_FFFF << w_ext_sh);
`else
    w_hi_bad = (rom_data[6:4] != 3'd0);
`endif
    w_err = 2'd0;
    if (w_last) begin
      if (rom_data[7])   w_err = 2'd1;
      else if (w_hi_bad) w_err = 2'd2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cur       <= '0;
      r_base      <= '0;
      r_acc       <= '0;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_signed    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      value       <= '0;
      nbytes      <= '0;
      next_addr   <= '0;
      err_code    <= '0;
      rom_addr    <= '0;
      rom_read_en <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cur       <= start_addr;
            r_base      <= start_addr;
            r_acc       <= '0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_tmo       <= '0;
`ifdef LEB128_SIGNED_EN
            r_signed    <= is_signed;
`else
            r_signed    <= 1'b0;
`endif
            rom_addr    <= start_addr;
            rom_read_en <= 1'b1;
            busy        <= 1'b1;
            r_state     <= FETCH;
          end
        end
        FETCH: begin
          if (rom_ready) begin
            r_acc <= w_acc;
            r_cnt <= w_cnt;
            if (w_term) begin
              done        <= 1'b1;
              value       <= w_val;
              nbytes      <= w_cnt;
              next_addr   <= r_base + {29'd0, w_cnt};
              err_code    <= w_err;
              rom_read_en <= 1'b0;
              r_state     <= FINISH;
            end else begin
              r_cur    <= r_cur + 32'd1;
              rom_addr <= r_cur + 32'd1;
              r_shift  <= r_shift + 5'd7;
              r_tmo    <= '0;
            end
          end else if (r_tmo == TW'(TIMEOUT - 1)) begin
            done        <= 1'b1;
            value       <= r_acc;
            nbytes      <= r_cnt;
            next_addr   <= r_base + {29'd0, r_cnt};
            err_code    <= 2'd3;
            rom_read_en <= 1'b0;
            r_state     <= FINISH;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        FINISH: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leb128_reader.sv
// Randomised + directed bench for leb128_reader against a byte-list LEB128 model and a behavioural ROM.
module tb_leb128_reader;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] start_addr = '0;
  logic        is_sg = 1'b0;
  logic        busy, done, rom_read_en;
  logic [31:0] value, next_addr, rom_addr;
  logic [2:0]  nbytes;
  logic [1:0]  err_code;
  logic [7:0]  rom_data = '0;
  logic        rom_ready = 1'b0;

  always #5 clk = ~clk;

  leb128_reader #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
`ifdef LEB128_SIGNED_EN
    .is_signed(is_sg),
`endif
    .busy(busy), .done(done), .value(value), .nbytes(nbytes), .next_addr(next_addr),
    .err_code(err_code), .rom_addr(rom_addr), .rom_read_en(rom_read_en),
    .rom_data(rom_data), .rom_ready(rom_ready)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural ROM: answers one cycle after a read, never twice in a row for one address.
  logic [7:0]  mem [0:255];
  logic [31:0] last = '0;
  bit          ls_valid = 0, silent = 0, spur = 0;
  logic [31:0] srv [$];

  initial begin
    logic en; logic [31:0] ad;
    forever begin
      @(negedge clk); en = rom_read_en; ad = rom_addr;
      @(posedge clk); #1;
      if (en && rst_n && !silent && !(ls_valid && ad == last)) begin
        rom_data = mem[ad[7:0]]; rom_ready = 1'b1;
        last = ad; ls_valid = 1; srv.push_back(ad);
      end else begin
        rom_data = 8'($urandom); rom_ready = spur;
      end
    end
  end

  typedef struct { logic [31:0] v; int n; int err; int lat; } res_t;

  // Collects the continuation-chained bytes into one wide integer, then applies range rules.
  function automatic res_t model(input logic [31:0] a, input bit sg, input bit blocked);
    res_t r; longint unsigned big; bit term; logic [7:0] b;
    big = 0; term = 0; r.n = 0;
    if (blocked) begin
      r.v = 0; r.err = 3; r.lat = TMO + 1; return r;
    end
    for (int i = 0; i < 5 && !term; i++) begin
      b = mem[8'(a + 32'(i))];
      big |= 64'(b[6:0]) << (7 * i);
      r.n = i + 1;
      term = !b[7];
    end
    r.v = big[31:0];
    r.lat = 2 * r.n + 1;
    if (!term) r.err = 1;
    else if (r.n == 5 && !sg && big[34:32] != 0) r.err = 2;
    else if (r.n == 5 && sg && !(big[34:31] == 4'h0 || big[34:31] == 4'hF)) r.err = 2;
    else r.err = 0;
    if (term && sg && r.n < 5 && big[7 * r.n - 1]) r.v = r.v | (32'hFFFF_FFFF << (7 * r.n));
    return r;
  endfunction

  // Expected transaction and results held after done
  bit          pending = 0;
  int          cyc = 0, e_lat = 0, e_n = 0, e_err = 0;
  logic [31:0] e_val = '0, e_a = '0, e_next = '0;
  logic [31:0] h_val = '0, h_next = '0;
  int          h_n = 0, h_err = 0;

  initial begin
    forever begin
      @(posedge clk); #2;
      if (!rst_n) continue;
      if (pending) begin
        cyc++;
        chk("busy_inflight", busy, 1);
        if (done) begin
          chk("latency", cyc, e_lat);
          chk("value", value, e_val);
          chk("nbytes", nbytes, e_n);
          chk("next_addr", next_addr, e_next);
          chk("err_code", err_code, e_err);
          chk("rd_en_at_done", rom_read_en, 0);
          chk("n_served", srv.size(), e_n);
          for (int i = 0; i < srv.size() && i < e_n; i++) chk("rom_addr_seq", srv[i], e_a + 32'(i));
          h_val = e_val; h_n = e_n; h_next = e_next; h_err = e_err;
          pending = 0;
        end else if (cyc >= e_lat) begin
          n_cmp++; n_bad++;
          $display("FAIL done_missing: no done after %0d cycles, expected at %0d", cyc, e_lat);
          pending = 0;
        end
      end else begin
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_rd_en", rom_read_en, 0);
        chk("hold_value", value, h_val);
        chk("hold_nbytes", nbytes, h_n);
        chk("hold_next", next_addr, h_next);
        chk("hold_err", err_code, h_err);
      end
    end
  end

  task automatic run(input logic [31:0] a, input bit sg, input int inj);
    res_t r;
    @(negedge clk);
    r = model(a, sg, silent || (ls_valid && a == last));
    e_val = r.v; e_n = r.n; e_err = r.err; e_lat = r.lat; e_a = a; e_next = a + 32'(r.n);
    srv.delete(); cyc = 0; pending = 1;
    start = 1; start_addr = a; is_sg = sg;
    @(negedge clk); start = 0;
    if (inj == 1) begin
      @(negedge clk); start = 1; start_addr = a + 32'h50;
      @(negedge clk); start = 0;
    end
    if (inj == 2) begin
      repeat (r.lat - 1) @(negedge clk);
      start = 1; start_addr = a + 32'h1;
      @(negedge clk); start = 0;
    end
    for (int k = 0; k < 200 && pending; k++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic put(input logic [31:0] a, input logic [39:0] bytes, input int n);
    for (int i = 0; i < n; i++) mem[8'(a + 32'(i))] = bytes[8*i +: 8];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    res_t pin;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    #12;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_value", value, 0);
    chk("rst_rom_addr", rom_addr, 0); chk("rst_rd_en", rom_read_en, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    put(32'h20, 40'h26_8E_E5, 3);
    pin = model(32'h20, 0, 0);
    chk("model_pin_624485", pin.v, 32'h0009_8765);

    put(32'h10, 40'h08, 1);
    run(32'h10, 0, 0);
    chk("lit_1byte", value, 32'h8); chk("lit_1byte_next", next_addr, 32'h11);
    run(32'h20, 0, 0);
    chk("lit_3byte", value, 32'h0009_8765); chk("lit_3byte_n", nbytes, 3);
    put(32'h30, 40'h0F_FF_FF_FF_FF, 5);
    run(32'h30, 0, 0);
    chk("lit_max", value, 32'hFFFF_FFFF); chk("lit_max_err", err_code, 0);
    put(32'h40, 40'h1F_FF_FF_FF_FF, 5);
    run(32'h40, 0, 0);
    chk("lit_overflow", err_code, 2);
    put(32'h50, 40'h80_80_80_80_80, 5);
    run(32'h50, 0, 0);
    chk("lit_overlong", err_code, 1); chk("lit_overlong_n", nbytes, 5);
    silent = 1;
    run(32'h60, 0, 0);
    chk("lit_timeout", err_code, 3);
    silent = 0;
    run(32'h54, 0, 0);
    chk("lit_reread", err_code, 3);
    run(32'h20, 0, 1);
    run(32'h10, 0, 2);

    @(negedge clk);
    pending = 1; cyc = 0; e_lat = 7; srv.delete();
    start = 1; start_addr = 32'h20; is_sg = 0;
    @(negedge clk); start = 0;
    repeat (2) @(negedge clk);
    rst_n = 0; pending = 0;
    h_val = 0; h_n = 0; h_next = 0; h_err = 0;
    #1;
    chk("abort_rd_en", rom_read_en, 0); chk("abort_busy", busy, 0); chk("abort_done", done, 0);
    chk("abort_value", value, 0); chk("abort_rom_addr", rom_addr, 0); chk("abort_next", next_addr, 0);
    @(negedge clk); rst_n = 1;
    repeat (4) @(negedge clk);
    run(32'h10, 0, 0);
    chk("lit_after_reset", value, 32'h8);

    put(32'hFFFF_FFFE, 40'h01_81_81, 3);
    run(32'hFFFF_FFFE, 0, 0);
    chk("lit_wrap_next", next_addr, 32'h1);

    @(negedge clk); spur = 1;
    @(negedge clk); spur = 0;
    repeat (2) @(negedge clk);

`ifdef LEB128_SIGNED_EN
    put(32'h80, 40'h7F, 1);
    run(32'h80, 1, 0); chk("lit_s_m1", value, 32'hFFFF_FFFF);
    put(32'h90, 40'h78_BB_C0, 3);
    run(32'h90, 1, 0); chk("lit_s_m123456", value, 32'hFFFE_1DC0);
    run(32'h80, 0, 0); chk("lit_u_7f", value, 32'h7F);
`endif

    for (int k = 0; k < 150; k++) begin
      logic [31:0] a; int n; bit sg;
      a = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                      : 32'($urandom_range(0, 255));
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        if (i < n - 1) b[7] = 1'b1;
        else if (n < 5 || $urandom_range(0, 1) == 0) b[7] = 1'b0;
        mem[8'(a + 32'(i))] = b;
      end
      sg = 0;
`ifdef LEB128_SIGNED_EN
      sg = 1'($urandom_range(0, 1));
`endif
      run(a, sg, 0);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/leb128_reader.md
Name: leb128_reader

Overview:
- Upstream fetch stage between the byte-wide ROM and the wasm module parser.
- On a start pulse, reads consecutive ROM bytes from a given address and decodes one LEB128 integer (u32; s32 optional).
- Returns the decoded value, the byte count, and the address after the last byte.
- The parser uses it for section sizes, counts, indices and immediates, so it never handles continuation bits itself.

Parameters:
- TIMEOUT, 16, cycles to wait for rom_ready per byte before aborting (must be ≥3).

Ports:
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request strobe; sampled only in IDLE
- start_addr  in  32  ROM address of first LEB byte, latched on accepted start
- busy  out  1  high from cycle after accepted start until done cycle inclusive
- done  out  1  one-cycle pulse; value/nbytes/next_addr/err_code valid and held until next accepted start
- value  out  32  decoded integer
- nbytes  out  3  bytes consumed, 1..5 (on error: bytes read so far)
- next_addr  out  32  start_addr + nbytes
- err_code  out  2  0 ok, 1 overlong (continuation on 5th byte), 2 overflow (unused high bits set in 5th byte), 3 timeout
- rom_addr  out  32  ROM byte address
- rom_read_en  out  1  ROM read request
- rom_data  in  8  ROM byte, valid while rom_ready high
- rom_ready  in  1  one-cycle ROM data-valid pulse

Behaviour:
- Reset (async, immediate): state IDLE; busy=0, done=0, value=0, nbytes=0, next_addr=0, err_code=0, rom_addr=0, rom_read_en=0; internal accumulator, shift and timeout counter cleared.
- States:
  - IDLE: on start, latch cur=start_addr, acc=0, shift=0, cnt=0, tmo=0 → FETCH.
  - FETCH: rom_read_en=1, rom_addr=cur. On rom_ready, acc |= rom_data[6:0] << shift, cnt+1, then:
    - rom_data[7]=0 → FINISH.
    - rom_data[7]=1 and cnt<4 → cur+1, shift+7, tmo=0, stay FETCH.
    - 5th byte with rom_data[7]=1 → err 1, FINISH.
    - 5th byte (unsigned) with rom_data[6:4]≠0 → err 2, FINISH.
  - FETCH timeout: tmo counts cycles without rom_ready; tmo==TIMEOUT-1 without ready → err 3, FINISH.
  - FINISH: drive done=1 for exactly one cycle, update outputs, rom_read_en=0 → IDLE.
- ROM timing:
  - The ROM answers one cycle after sampling read_en, and only when the address differs from its previous access.
  - rom_read_en stays high across bytes; rom_addr advances on the edge after rom_ready.
  - Throughput is one byte per 2 cycles; a 1-byte decode completes with done 3 cycles after start.
- Re-reading the same address the ROM last served will not answer; the parser must avoid this, and the result is err 3, not a hang.
- Width rules: shift is 0,7,14,21,28; the 5th byte contributes only bits [3:0]; next_addr wraps modulo 2^32.
- Simultaneous events:
  - start while busy is ignored.
  - start in the FINISH cycle is ignored.
  - start the cycle after done is accepted.
- rom_ready in IDLE is ignored.
- rst_n low mid-FETCH aborts at once: rom_read_en drops asynchronously and no done is produced.

Optional Feature:
- Macro: LEB128_SIGNED_EN.
- Defined:
  - Adds input is_signed (1 bit, latched with start).
  - When set, on the terminating byte with shift+7<32 and rom_data[6]=1, value bits above shift+7 are filled with 1.
  - On a 5th byte, rom_data[6:3] must be all-0 or all-1, else err 2.
- Undefined: the port is absent; all decodes are unsigned; the 5th-byte check is rom_data[6:4]==0.

Test Plan:
- ROM[0x10]=0x08, start_addr=0x10 → done after 3 cycles, value=0x8, nbytes=1, next_addr=0x11, err_code=0.
- ROM[0x20..22]=E5 8E 26 → value=0x00098765 (624485), nbytes=3, next_addr=0x23, rom_addr sequence 0x20,0x21,0x22.
- ROM=FF FF FF FF 0F → value=0xFFFFFFFF, nbytes=5, err_code=0.
- ROM=FF FF FF FF 1F → err_code=2.
- ROM=80 80 80 80 80 → err_code=1, nbytes=5.
- ROM model held silent → done with err_code=3 exactly TIMEOUT cycles after FETCH entry; rom_read_en low after done.
- Reset mid-decode: assert rst_n=0 during 2nd byte → no done; all outputs at reset values.
- Reset then start at 0x10 → correct 0x8 result.
- Start pulse while busy ignored (rom_addr unaffected).
- (LEB128_SIGNED_EN) is_signed=1, ROM=7F → value=0xFFFFFFFF.
- (LEB128_SIGNED_EN) is_signed=1, ROM=C0 BB 78 → value=0xFFFE1DC0 (−123456).
- (LEB128_SIGNED_EN) is_signed=0, ROM=7F → value=0x7F.
